// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: default widths,
// FSM state encoding and a small address-alignment helper.
package mem_arb_pkg;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_D = 2'd1;
    localparam logic [1:0] ST_GNT_I = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StGntD = ST_GNT_D,
        StGntI = ST_GNT_I,
        StResp = ST_RESP
    } arb_state_e;

    // Word accesses only: the two low address bits must be zero.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM
// stage. One access at a time: IDLE -> GNT_x (held until ack) -> RESP.
// Data wins contention unless a waiting fetch has been passed over
// STARVE_MAX times in a row.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,

    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          d_misalign,

    output logic          stall,

    output logic          ram_req,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_ack
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e state;
    logic [3:0] starve_cnt;

    logic d_req;
    logic d_aligned;

    assign d_req     = d_rd | d_wr;
    assign d_aligned = is_word_aligned(d_addr[1:0]);

    // Hold the pipeline while either requester is waiting for its ready pulse.
    assign stall = (d_req & ~d_ready) | (if_req & ~if_ready);

    // Arbitration FSM, starvation counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            starve_cnt <= '0;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_rdata   <= '0;
            if_ready   <= 1'b0;
            d_rdata    <= '0;
            d_ready    <= 1'b0;
            d_misalign <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            d_misalign <= 1'b0;

            case (state)
                StIdle: begin
                    if (!if_req) begin
                        starve_cnt <= '0;
                    end

                    if (d_req && !d_aligned) begin
                        // Dropped access: report it without touching memory.
                        d_misalign <= 1'b1;
                        d_ready    <= 1'b1;
                        d_rdata    <= '0;
                        state      <= StResp;
                    end else if (d_req && (!if_req || starve_cnt != STARVE_LIM)) begin
                        ram_req   <= 1'b1;
                        ram_we    <= d_wr;
                        ram_addr  <= d_addr;
                        ram_wdata <= d_wr ? d_wdata : '0;
                        if (if_req && starve_cnt != STARVE_LIM) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                        state <= StGntD;
                    end else if (if_req) begin
                        ram_req    <= 1'b1;
                        ram_we     <= 1'b0;
                        ram_addr   <= if_addr;
                        ram_wdata  <= '0;
                        starve_cnt <= '0;
                        state      <= StGntI;
                    end
                end

                StGntD: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                        // Stores return no data.
                        d_rdata <= ram_we ? '0 : ram_rdata;
                        d_ready <= 1'b1;
                        state   <= StResp;
                    end
                end

                StGntI: begin
                    if (ram_ack) begin
                        ram_req  <= 1'b0;
                        if_rdata <= ram_rdata;
                        if_ready <= 1'b1;
                        state    <= StResp;
                    end
                end

                StResp: begin
                    // No grant here, so a request held through its ready cycle is not re-served.
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory model
// (programmable wait states) and an in-order completion scoreboard.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          d_misalign;
    logic          stall;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_ack;

    logic mdl_ack = 1'b0;
    logic man_ack;
    int   mem_wait;
    int   wcnt = 0;

    typedef struct {
        logic        is_data;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW),
        .DW(DW),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_rdata(if_rdata),
        .if_ready(if_ready),
        .d_rd(d_rd),
        .d_wr(d_wr),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_ready(d_ready),
        .d_misalign(d_misalign),
        .stall(stall),
        .ram_req(ram_req),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .ram_ack(ram_ack)
    );

    // Memory contents as seen by the bench.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h8C01_0004;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    function automatic exp_t mk(input logic is_data, input logic [31:0] data, input logic mis);
        exp_t e;
        e.is_data = is_data;
        e.data    = data;
        e.mis     = mis;
        return e;
    endfunction

    assign ram_rdata = mem_val(ram_addr);
    assign ram_ack   = mdl_ack | man_ack;

    // Memory model: ack after mem_wait wait cycles of a held request.
    always @(negedge clk) begin
        if (ram_req) begin
            if (wcnt >= mem_wait) begin
                mdl_ack <= 1'b1;
                wcnt    <= 0;
            end else begin
                mdl_ack <= 1'b0;
                wcnt    <= wcnt + 1;
            end
        end else begin
            mdl_ack <= 1'b0;
            wcnt    <= 0;
        end
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare the current ready pulse against the oldest expected completion.
    task automatic sb_pop(input string tag);
        exp_t e;
        chk1({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk1({tag, "_d_ready"}, d_ready, e.is_data);
            chk1({tag, "_if_ready"}, if_ready, ~e.is_data);
            chk1({tag, "_misalign"}, d_misalign, e.mis);
            if (e.is_data) chk32({tag, "_d_rdata"}, d_rdata, e.data);
            else chk32({tag, "_if_rdata"}, if_rdata, e.data);
        end
    endtask

    task automatic wait_ready(input string tag, input int budget, output int n);
        n = 0;
        while (!(if_ready || d_ready) && n < budget) begin
            step(1);
            n++;
        end
        chk1({tag, "_ready_seen"}, if_ready | d_ready, 1'b1);
        if (if_ready || d_ready) sb_pop(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        int r;
        int cyc;
        int rc;

        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        d_rd     = 1'b0;
        d_wr     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        man_ack  = 1'b0;
        mem_wait = 0;
        step(2);

        chk1("rst_ram_req", ram_req, 1'b0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk1("rst_if_ready", if_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        chk1("rst_misalign", d_misalign, 1'b0);
        chk32("rst_ram_addr", ram_addr, 32'h0);
        chk32("rst_ram_wdata", ram_wdata, 32'h0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        chk1("rst_stall", stall, 1'b0);
        rst = 1'b0;
        step(1);

        // Fetch only, zero-wait memory.
        if_req  = 1'b1;
        if_addr = 32'h40;
        sb.push_back(mk(1'b0, 32'h8C01_0004, 1'b0));
        #1;
        chk1("f_stall_on", stall, 1'b1);
        step(1);
        chk1("f_ram_req", ram_req, 1'b1);
        chk32("f_ram_addr", ram_addr, 32'h40);
        chk1("f_ram_we", ram_we, 1'b0);
        chk1("f_not_ready_yet", if_ready, 1'b0);
        step(1);
        chk1("f_stall_off", stall, 1'b0);
        chk1("f_ram_req_off", ram_req, 1'b0);
        sb_pop("fetch");
        step(1);
        chk1("f_req_once", ram_req, 1'b0);
        chk1("f_ready_pulse", if_ready, 1'b0);
        if_req = 1'b0;

        // Load and fetch together; data wins, load has 2 wait states.
        mem_wait = 2;
        d_rd     = 1'b1;
        d_addr   = 32'h100;
        if_req   = 1'b1;
        if_addr  = 32'h80;
        sb.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b0));
        sb.push_back(mk(1'b0, mem_val(32'h80), 1'b0));
        wait_ready("ld_first", 10, n);
        chk32("ld_latency", n, 32'd4);
        chk1("ld_stall_fetch_waits", stall, 1'b1);
        mem_wait = 0;
        step(1);
        d_rd = 1'b0;
        wait_ready("if_second", 10, n);
        chk32("if_second_latency", n, 32'd2);
        step(1);
        if_req = 1'b0;

        // Store with one wait state: request fields held until ack.
        mem_wait = 1;
        d_wr     = 1'b1;
        d_addr   = 32'h104;
        d_wdata  = 32'h1234_5678;
        sb.push_back(mk(1'b1, 32'h0, 1'b0));
        step(1);
        chk1("st_ram_req", ram_req, 1'b1);
        chk1("st_ram_we", ram_we, 1'b1);
        chk32("st_ram_addr", ram_addr, 32'h104);
        chk32("st_ram_wdata", ram_wdata, 32'h1234_5678);
        step(1);
        chk1("st_ram_req_held", ram_req, 1'b1);
        chk1("st_ram_we_held", ram_we, 1'b1);
        chk32("st_ram_wdata_held", ram_wdata, 32'h1234_5678);
        wait_ready("st", 5, n);
        chk32("st_latency", n, 32'd1);
        step(1);
        d_wr    = 1'b0;
        d_wdata = '0;

        // Misaligned load: dropped, reported next cycle.
        d_rd   = 1'b1;
        d_addr = 32'h102;
        sb.push_back(mk(1'b1, 32'h0, 1'b1));
        step(1);
        chk1("mis_no_ram_req", ram_req, 1'b0);
        sb_pop("mis");
        chk1("mis_stall", stall, 1'b0);
        step(1);
        d_rd = 1'b0;
        chk1("mis_no_ram_req2", ram_req, 1'b0);
        chk1("mis_pulse", d_misalign, 1'b0);

        // Continuous data and fetch requests: 4 data grants then 1 fetch.
        mem_wait = 0;
        d_rd     = 1'b1;
        d_addr   = 32'h200;
        if_req   = 1'b1;
        if_addr  = 32'h300;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) sb.push_back(mk(1'b0, mem_val(32'h300), 1'b0));
            else sb.push_back(mk(1'b1, mem_val(32'h200), 1'b0));
        end
        g   = 0;
        r   = 0;
        cyc = 0;
        while ((g < 10 || r < 10) && cyc < 60) begin
            step(1);
            cyc++;
            if (ram_req) begin
                chk32($sformatf("grant%0d_addr", g), ram_addr,
                      (g % 5 == 4) ? 32'h300 : 32'h200);
                g++;
            end
            if (if_ready || d_ready) begin
                sb_pop($sformatf("starve%0d", r));
                r++;
            end
        end
        chk32("starve_grants", g, 32'd10);
        chk32("starve_readies", r, 32'd10);
        step(1);
        d_rd   = 1'b0;
        if_req = 1'b0;
        step(1);

        // Reset during GNT_D; the late ack must be ignored.
        mem_wait = 20;
        d_rd     = 1'b1;
        d_addr   = 32'h100;
        step(1);
        chk1("rr_ram_req", ram_req, 1'b1);
        step(1);
        chk1("rr_ram_req_wait", ram_req, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rr_ram_req_clr", ram_req, 1'b0);
        chk1("rr_ram_we_clr", ram_we, 1'b0);
        chk32("rr_ram_addr_clr", ram_addr, 32'h0);
        chk32("rr_d_rdata_clr", d_rdata, 32'h0);
        chk32("rr_if_rdata_clr", if_rdata, 32'h0);
        chk1("rr_d_ready_clr", d_ready, 1'b0);
        d_rd = 1'b0;
        step(1);
        rst     = 1'b0;
        man_ack = 1'b1;
        rc      = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (i == 1) man_ack = 1'b0;
            if (if_ready || d_ready || ram_req) rc++;
        end
        chk32("rr_late_ack_ignored", rc, 32'd0);
        chk32("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
